// File: rtl/bg_scroll_ctrl.sv
// bg_scroll_ctrl
//   Background scroll controller. Each frame it adds `speed` to the fine
//   scroll offset. When the offset passes a full 16-pixel tile, it shifts
//   every tile in rows FIRST_ROW..LAST_ROW one column to the left in the
//   tilemap RAM. It then writes a freshly generated tile into the rightmost
//   column of each row.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   frame_tick one-cycle pulse at vblank start
//   game_over  blocks new scroll steps while high
//   speed      scroll pixels per frame (0..7)
//   rd_data    tilemap read data, valid the cycle after rd_addr
//   rd_addr    tilemap read address
//   wr_en      tilemap write strobe
//   wr_addr    tilemap write address
//   wr_data    tilemap write data
//   x_offset   fine scroll offset to the background engine
//   busy       high while a column shift is in progress
module bg_scroll_ctrl #(
    parameter int          FIRST_ROW = 5,
    parameter int          LAST_ROW  = 29,
    parameter int          COLS      = 40,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        game_over,
    input  logic [2:0]  speed,
    input  logic [15:0] rd_data,
    output logic [15:0] rd_addr,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic [3:0]  x_offset,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, NEWCOL, DONE} state_t;

    localparam logic [7:0]  FIRST_R   = 8'(FIRST_ROW);
    localparam logic [7:0]  LAST_R    = 8'(LAST_ROW);
    localparam logic [7:0]  LAST_COL  = 8'(COLS - 1);
    localparam logic [7:0]  LAST_READ = 8'(COLS - 2);
    localparam logic [15:0] COLS16    = 16'(COLS);

    state_t      state_q, state_d;
    logic [7:0]  row_q, row_d;
    logic [7:0]  col_q, col_d;
    logic [3:0]  x_q, x_d;
    logic [3:0]  pend_q, pend_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [4:0]  sum;
    logic        lfsr_fb;

    function automatic logic [15:0] tile_addr(input logic [7:0] r, input logic [7:0] c);
        return 16'(c) + 16'(r) * COLS16;
    endfunction

    assign sum      = {1'b0, x_q} + {2'b00, speed};
    // Right-shifting form of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR
    assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign x_offset = x_q;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            x_q     <= '0;
            pend_q  <= '0;
            lfsr_q  <= SEED;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            x_q     <= x_d;
            pend_q  <= pend_d;
            lfsr_q  <= lfsr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        x_d     = x_q;
        pend_d  = pend_q;
        lfsr_d  = lfsr_q;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        case (state_q)
            IDLE: begin
                if (frame_tick && !game_over) begin
                    if (!sum[4]) begin
                        x_d = sum[3:0];
                    end else begin
                        pend_d  = sum[3:0];
                        row_d   = FIRST_R;
                        col_d   = '0;
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                // The cycle with col=c reads cell c+1 and writes cell c-1
                // from the data read on the previous cycle. The col=COLS-1
                // cycle only drains the last write.
                if (col_q <= LAST_READ) begin
                    rd_addr = tile_addr(row_q, col_q + 8'd1);
                end
                if (col_q != 8'd0) begin
                    wr_en   = 1'b1;
                    wr_addr = tile_addr(row_q, col_q - 8'd1);
                    wr_data = rd_data;
                end
                if (col_q == LAST_COL) begin
                    state_d = NEWCOL;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end

            NEWCOL: begin
                wr_en   = 1'b1;
                wr_addr = tile_addr(row_q, LAST_COL);
                if (row_q == LAST_R) begin
                    wr_data = 16'h0108;
                end else begin
                    wr_data = {7'b0, (lfsr_q[3:0] == 4'd0), 2'b00, 3'd2, lfsr_q[6:4]};
                end
                lfsr_d = {lfsr_fb, lfsr_q[15:1]};
                if (row_q == LAST_R) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + 8'd1;
                    col_d   = '0;
                    state_d = SHIFT;
                end
            end

            DONE: begin
                x_d     = pend_q;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// tb_bg_scroll_ctrl
//   Randomized bench for bg_scroll_ctrl. It drives the block against a
//   tilemap RAM model. A reference model keeps the scroll offset, a shadow
//   tilemap and the LFSR, and checks them against the DUT after every frame.
module tb_bg_scroll_ctrl;

    localparam int FIRST_ROW = 5;
    localparam int LAST_ROW  = 29;
    localparam int COLS      = 40;
    localparam int NROWS     = LAST_ROW - FIRST_ROW + 1;
    localparam int MEM_USED  = (LAST_ROW + 1) * COLS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        game_over;
    logic [2:0]  speed;
    logic [15:0] rd_data;
    logic [15:0] rd_addr;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  x_offset;
    logic        busy;

    always #5 clk = ~clk;

    bg_scroll_ctrl #(
        .FIRST_ROW(FIRST_ROW),
        .LAST_ROW (LAST_ROW),
        .COLS     (COLS),
        .SEED     (16'hACE1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .game_over (game_over),
        .speed     (speed),
        .rd_data   (rd_data),
        .rd_addr   (rd_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .x_offset  (x_offset),
        .busy      (busy)
    );

    // Tilemap RAM model with a one-cycle read latency
    logic [15:0] mem [0:2047];
    int          wr_cnt, nc_cnt, bad_wr;
    bit          got_first;
    logic [15:0] first_addr, first_data;

    always @(posedge clk) begin
        rd_data <= mem[rd_addr[10:0]];
        if (wr_en) begin
            mem[wr_addr[10:0]] <= wr_data;
            wr_cnt++;
            if (int'(wr_addr) < FIRST_ROW * COLS || int'(wr_addr) >= MEM_USED) bad_wr++;
            if (int'(wr_addr) % COLS == COLS - 1) nc_cnt++;
            if (!got_first) begin
                got_first  = 1'b1;
                first_addr = wr_addr;
                first_data = wr_data;
            end
        end
    end

    // Reference model state
    int unsigned ref_mem [0:MEM_USED-1];
    int unsigned ref_lfsr;
    int          ref_x;
    int          n_cmp, n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned lfsr_step(input int unsigned l);
        int unsigned b;
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return ((l >> 1) | (b << 15)) & 16'hFFFF;
    endfunction

    task automatic model_shift();
        for (int r = FIRST_ROW; r <= LAST_ROW; r++) begin
            for (int c = 0; c < COLS - 1; c++)
                ref_mem[r*COLS + c] = ref_mem[r*COLS + c + 1];
            if (r == LAST_ROW)
                ref_mem[r*COLS + COLS - 1] = 16'h0108;
            else
                ref_mem[r*COLS + COLS - 1] = (((ref_lfsr & 15) == 0) ? 256 : 0) | (2 << 3) | ((ref_lfsr >> 4) & 7);
            ref_lfsr = lfsr_step(ref_lfsr);
        end
    endtask

    task automatic compare_mem();
        int errs, top_errs;
        errs = 0;
        top_errs = 0;
        for (int i = 0; i < MEM_USED; i++) begin
            if (32'(mem[i]) != ref_mem[i]) errs++;
            if (i < FIRST_ROW * COLS && int'(mem[i]) != i) top_errs++;
        end
        check("tilemap", errs, 0);
        check("top_rows", top_errs, 0);
    endtask

    task automatic frame(input int spd, input bit go, input bit disturb);
        int  s, cyc;
        bit  will_shift;
        s          = ref_x + spd;
        will_shift = !go && s >= 16;
        wr_cnt     = 0;
        nc_cnt     = 0;
        got_first  = 1'b0;
        speed      = 3'(spd);
        game_over  = go;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        if (!will_shift) begin
            if (!go) ref_x = s;
            check("x_step", x_offset, ref_x);
            check("busy_idle", busy, 0);
            check("no_write", wr_cnt, 0);
        end else begin
            check("busy_rise", busy, 1);
            cyc = 1;
            while (busy && cyc < 3000) begin
                if (disturb) begin
                    frame_tick = ($urandom_range(0, 15) == 0);
                    game_over  = 1'($urandom_range(0, 1));
                end
                @(posedge clk); #1;
                cyc++;
            end
            frame_tick = 1'b0;
            game_over  = 1'b0;
            check("shift_done", busy, 0);
            check("shift_len_ok", (cyc >= NROWS*(COLS+1) && cyc <= NROWS*(COLS+1) + 8), 1);
            model_shift();
            ref_x = s - 16;
            check("x_after", x_offset, ref_x);
            check("wr_count", wr_cnt, NROWS * COLS);
            check("newcol_cnt", nc_cnt, NROWS);
            compare_mem();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; bad_wr = 0; wr_cnt = 0; nc_cnt = 0; got_first = 1'b0;
        rst_n = 1'b0; frame_tick = 1'b0; game_over = 1'b0; speed = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'(i);
        for (int i = 0; i < MEM_USED; i++) ref_mem[i] = i;
        ref_lfsr = 16'hACE1;
        ref_x    = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_x", x_offset, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed steps up to 14, then a step that crosses a tile
        frame(5, 0, 0);
        frame(7, 0, 0);
        frame(2, 0, 0);
        frame(3, 0, 0);
        check("first_wr_addr", first_addr, 200);
        check("first_wr_data", first_data, 201);
        check("ground_tile", mem[LAST_ROW*COLS + COLS - 1], 16'h0108);

        repeat (4) frame($urandom_range(1, 7), 1, 0);
        frame(0, 0, 0);

        for (int k = 0; k < 14; k++)
            frame($urandom_range(0, 7), ($urandom_range(0, 4) == 0), 1);

        // Reset in the middle of a shift
        while (ref_x < 9) frame(7, 0, 0);
        speed = 3'd7; game_over = 1'b0; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (299) @(posedge clk);
        #1;
        check("busy_mid", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", busy, 0);
        check("midrst_wr_en", wr_en, 0);
        check("midrst_x", x_offset, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < MEM_USED; i++) ref_mem[i] = 32'(mem[i]);
        ref_x    = 0;
        ref_lfsr = 16'hACE1;
        frame(7, 0, 0);
        frame(7, 0, 0);
        frame(7, 0, 0);

        check("rows_in_range", bad_wr, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bg_scroll_ctrl.md
BG_SCROLL_CTRL -- requirements
Module: bg_scroll_ctrl

Interface
REQ-001 SHALL have parameter FIRST_ROW, default 5, meaning the first scrolled tilemap row.
REQ-002 SHALL have parameter LAST_ROW, default 29, meaning the last scrolled tilemap row (ground row).
REQ-003 SHALL have parameter COLS, default 40, meaning tile columns per row (640/16).
REQ-004 SHALL have parameter SEED, default 16'hACE1, meaning the LFSR reset value.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 frame_tick  in  1  one-cycle pulse at vblank start.
REQ-008 game_over  in  1  freezes scrolling while high.
REQ-009 speed  in  3  scroll pixels per frame, 0..7.
REQ-010 rd_data  in  16  tilemap RAM read data, valid one cycle after rd_addr.
REQ-011 rd_addr  out  16  tilemap RAM read address.
REQ-012 wr_en  out  1  tilemap RAM write strobe.
REQ-013 wr_addr  out  16  tilemap RAM write address.
REQ-014 wr_data  out  16  tilemap RAM write data (tile word: [2:0] col, [5:3] row, [6] xflip, [7] yflip, [8] enable).
REQ-015 x_offset  out  4  fine scroll offset to the background engine.
REQ-016 busy  out  1  high while a column shift is in progress.

Function
REQ-017 Tile address SHALL be col + row*COLS, 16-bit.
REQ-018 FSM states SHALL be IDLE, SHIFT, NEWCOL, DONE.
REQ-019 In IDLE, frame_tick with game_over=0 SHALL compute sum = x_offset + speed as a 5-bit value.
REQ-020 If sum < 16, x_offset SHALL take sum[3:0] on the next cycle and the FSM SHALL stay in IDLE.
REQ-021 If sum >= 16, the block SHALL latch pend = sum - 16, enter SHIFT with row=FIRST_ROW and col=0, and leave x_offset unchanged.
REQ-022 In SHIFT, each cycle SHALL issue rd_addr = addr(row, col+1).
REQ-023 One cycle after each read, SHIFT SHALL write wr_addr = addr(row, col) with wr_data = rd_data and wr_en=1, pipelined at one cell per cycle.
REQ-024 After reading col = COLS-2, SHIFT SHALL go to NEWCOL once the last pipelined write has issued.
REQ-025 NEWCOL SHALL write exactly one word to addr(row, COLS-1).
REQ-026 NEWCOL data for row == LAST_ROW SHALL be 16'h0108.
REQ-027 NEWCOL data for all other rows SHALL be {7'b0, enable=(lfsr[3:0]==0), 2'b00, 3'd2, lfsr[6:4]}.
REQ-028 The LFSR SHALL be 16-bit Fibonacci with taps 16,14,13,11, and SHALL advance once per NEWCOL write only.
REQ-029 After NEWCOL, row < LAST_ROW SHALL return to SHIFT with row+1 and col=0; row == LAST_ROW SHALL go to DONE.
REQ-030 DONE SHALL load x_offset = pend and return to IDLE in one cycle.
REQ-031 busy SHALL be 1 in SHIFT, NEWCOL and DONE, and 0 in IDLE.
REQ-032 A full shift SHALL take (LAST_ROW-FIRST_ROW+1)*(COLS+1)+O(1) cycles (~1030), well inside vblank.
REQ-033 frame_tick SHALL be ignored while busy=1; no queuing.
REQ-034 game_over=1 SHALL block new scroll starts, SHALL NOT abort a shift in progress, and SHALL leave x_offset holding.
REQ-035 speed=0 SHALL cause no state change.
REQ-036 wr_en SHALL be 0 outside the SHIFT writes and NEWCOL.
REQ-037 No write SHALL ever target rows outside FIRST_ROW..LAST_ROW.

Reset
REQ-038 With rst_n=0 at a clock edge, the block SHALL enter IDLE with x_offset=0, busy=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, lfsr=SEED and pend=0.
REQ-039 Reset SHALL take priority mid-shift; the partially shifted tilemap is left as-is.

Verification
REQ-040 x_offset=0, speed=5, one frame_tick -> x_offset=5, no wr_en, busy=0.
REQ-041 x_offset=14, speed=3, frame_tick -> busy rises, first write addr 200 gets data read from 201; row 29 col 39 gets 16'h0108; DONE leaves x_offset=1, busy=0.
REQ-042 Model RAM preloaded with addr-valued words, one shift -> every cell (r,c), r in 5..29, c<39, holds old (r,c+1); rows 0-4 untouched; 25 NEWCOL writes whose data matches the reference LFSR sequence from 16'hACE1.
REQ-043 game_over=1 with repeated frame_ticks -> x_offset constant, no writes; game_over raised mid-shift -> shift completes normally.
REQ-044 frame_tick pulsed during busy -> ignored; the shift count stays 1 and x_offset equals the single-step result.
REQ-045 rst_n=0 at cycle 300 of a shift -> next cycle IDLE, x_offset=0, wr_en=0, busy=0, lfsr=16'hACE1.
